// File: rtl/arith_encoder_pkg.sv
// rtl/arith_encoder_pkg.sv - shared constants and types for the arithmetic encoder
package arith_encoder_pkg;

    localparam int CDF_PROB_TOP  = 32768;
    localparam int EC_PROB_SHIFT = 6;
    localparam int EC_MIN_PROB   = 4;
    localparam logic [15:0] RANGE_RESET = 16'h8000;

    localparam int RANGE_W  = 16;
    localparam int LOW_W    = 24;
    localparam int SYMBOL_W = 4;

    typedef logic [RANGE_W-1:0]  range_t;
    typedef logic [LOW_W-1:0]    low_t;
    typedef logic [SYMBOL_W-1:0] symbol_t;

endpackage

// File: rtl/arith_min_prob_lut.sv
// rtl/arith_min_prob_lut.sv - minimum-probability term 4*(N-s), zero when s > N
module arith_min_prob_lut
    import arith_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    localparam int HALF = ADDR_WIDTH / 2;

    logic [HALF-1:0] n_idx;
    logic [HALF-1:0] s_idx;

    assign n_idx = addr[ADDR_WIDTH-1:HALF];
    assign s_idx = addr[HALF-1:0];

    always_comb begin
        data = '0;
        if (s_idx <= n_idx) begin
            data = DATA_WIDTH'(EC_MIN_PROB * (int'(n_idx) - int'(s_idx)));
        end
    end

endmodule

// File: rtl/arithmetic_encoder.sv
// rtl/arithmetic_encoder.sv - single-stage range/low update with normalization, one symbol per clock
module arithmetic_encoder
    import arith_encoder_pkg::*;
#(
    parameter int GENERAL_RANGE_WIDTH    = 16,
    parameter int GENERAL_LOW_WIDTH      = 24,
    parameter int GENERAL_SYMBOL_WIDTH   = 4,
    parameter int GENERAL_LUT_ADDR_WIDTH = 8,
    parameter int GENERAL_LUT_DATA_WIDTH = 16,
    parameter int GENERAL_D_SIZE         = 4
) (
    input  logic                            general_clk,
    input  logic                            reset,
    input  logic [GENERAL_RANGE_WIDTH-1:0]  general_fl,
    input  logic [GENERAL_RANGE_WIDTH-1:0]  general_fh,
    input  logic [GENERAL_SYMBOL_WIDTH-1:0] general_symbol,
    input  logic [GENERAL_SYMBOL_WIDTH:0]   general_nsyms,
    output logic [GENERAL_RANGE_WIDTH-1:0]  RANGE_OUTPUT,
    output logic [GENERAL_LOW_WIDTH-1:0]    LOW_OUTPUT
);

    localparam int RW = GENERAL_RANGE_WIDTH;
    localparam int LW = GENERAL_LOW_WIDTH;
    localparam int SW = GENERAL_SYMBOL_WIDTH;

    logic [SW-1:0]                     n_low;
    logic [GENERAL_LUT_ADDR_WIDTH-1:0] lut_addr;
    logic [GENERAL_LUT_DATA_WIDTH-1:0] lut_data;

    assign n_low    = SW'(general_nsyms - (SW+1)'(1));
    assign lut_addr = GENERAL_LUT_ADDR_WIDTH'({n_low, general_symbol});

    arith_min_prob_lut #(
        .ADDR_WIDTH (GENERAL_LUT_ADDR_WIDTH),
        .DATA_WIDTH (GENERAL_LUT_DATA_WIDTH)
    ) u_lut (
        .addr (lut_addr),
        .data (lut_data)
    );

    logic [31:0]               q;
    logic [31:0]               fl_s;
    logic [31:0]               fh_s;
    logic [31:0]               u;
    logic [31:0]               v;
    logic [RW-1:0]             r_mid;
    logic [LW-1:0]             low_mid;
    logic [GENERAL_D_SIZE-1:0] d;
    logic [RW-1:0]             range_next;
    logic [LW-1:0]             low_next;

    assign q    = 32'(RANGE_OUTPUT >> 8);
    assign fl_s = 32'(general_fl >> EC_PROB_SHIFT);
    assign fh_s = 32'(general_fh >> EC_PROB_SHIFT);
    assign u    = ((q * fl_s) >> 1) + 32'(lut_data) + 32'(EC_MIN_PROB);
    assign v    = ((q * fh_s) >> 1) + 32'(lut_data);

    // Symbol 0 (fl at the top of the CDF) keeps low and trims range from above.
    always_comb begin
        r_mid   = '0;
        low_mid = LOW_OUTPUT;
        if (32'(general_fl) < 32'(CDF_PROB_TOP)) begin
            r_mid   = RW'(u) - RW'(v);
            low_mid = LOW_OUTPUT + LW'(RANGE_OUTPUT) - LW'(u);
        end else begin
            r_mid   = RANGE_OUTPUT - RW'(v);
        end
    end

    // Ascending scan: the highest set bit wins, leaving d = 0 when r_mid is zero.
    always_comb begin
        d = '0;
        for (int i = 0; i < RW; i++) begin
            if (r_mid[i]) begin
                d = GENERAL_D_SIZE'(RW - 1 - i);
            end
        end
    end

    assign range_next = r_mid << d;
    assign low_next   = low_mid << d;

    always_ff @(posedge general_clk) begin
        if (reset) begin
            RANGE_OUTPUT <= RW'(RANGE_RESET);
            LOW_OUTPUT   <= '0;
        end else begin
            RANGE_OUTPUT <= range_next;
            LOW_OUTPUT   <= low_next;
        end
    end

endmodule

// File: tb/tb_arithmetic_encoder.sv
// tb/tb_arithmetic_encoder.sv - directed and randomized checks against an arithmetic reference model
module tb_arithmetic_encoder;

    logic        general_clk = 1'b0;
    logic        reset;
    logic [15:0] general_fl;
    logic [15:0] general_fh;
    logic [3:0]  general_symbol;
    logic [4:0]  general_nsyms;
    logic [15:0] RANGE_OUTPUT;
    logic [23:0] LOW_OUTPUT;

    int n_checks = 0;
    int n_fail   = 0;

    longint m_range;
    longint m_low;

    arithmetic_encoder dut (
        .general_clk    (general_clk),
        .reset          (reset),
        .general_fl     (general_fl),
        .general_fh     (general_fh),
        .general_symbol (general_symbol),
        .general_nsyms  (general_nsyms),
        .RANGE_OUTPUT   (RANGE_OUTPUT),
        .LOW_OUTPUT     (LOW_OUTPUT)
    );

    always #5 general_clk = ~general_clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: formulas in plain integer arithmetic; normalize by doubling until the top bit is set.
    task automatic model_encode(input int fl, input int fh, input int s, input int nsyms);
        longint r, q, n, minp, u, v, lowp, rp;
        r    = m_range;
        q    = r / 256;
        n    = (nsyms - 1) & 15;
        minp = (s <= n) ? 4 * (n - s) : 0;
        if (fl < 32768) begin
            u    = ((q * (fl / 64)) / 2) + minp + 4;
            v    = ((q * (fh / 64)) / 2) + minp;
            lowp = m_low + r - u;
            rp   = (u - v) & 64'hFFFF;
        end else begin
            v    = ((q * (fh / 64)) / 2) + minp;
            lowp = m_low;
            rp   = (r - v) & 64'hFFFF;
        end
        while (rp != 0 && rp < 32768) begin
            rp   = rp * 2;
            lowp = lowp * 2;
        end
        m_range = rp;
        m_low   = lowp & 64'hFFFFFF;
    endtask

    task automatic apply(input bit rst, input int fl, input int fh, input int s, input int nsyms);
        reset          = rst;
        general_fl     = 16'(fl);
        general_fh     = 16'(fh);
        general_symbol = 4'(s);
        general_nsyms  = 5'(nsyms);
        @(posedge general_clk);
        #1;
        if (rst) begin
            m_range = 32768;
            m_low   = 0;
        end else begin
            model_encode(fl, fh, s, nsyms);
        end
    endtask

    task automatic step_check(input bit rst, input int fl, input int fh, input int s,
                              input int nsyms, input string tag);
        apply(rst, fl, fh, s, nsyms);
        check({tag, "_range"}, longint'(RANGE_OUTPUT), m_range);
        check({tag, "_low"}, longint'(LOW_OUTPUT), m_low);
    endtask

    initial begin
        int fl, fh, s, ns;
        bit rst;

        m_range = 32768;
        m_low   = 0;

        apply(1'b1, 0, 0, 0, 0);
        apply(1'b1, 1234, 55, 7, 3);
        check("reset_range", longint'(RANGE_OUTPUT), 32768);
        check("reset_low", longint'(LOW_OUTPUT), 0);

        apply(1'b0, 9690, 3202, 3, 10);
        check("ex1_edge1_range", longint'(RANGE_OUTPUT), 51744);
        check("ex1_edge1_low", longint'(LOW_OUTPUT), 184608);
        apply(1'b0, 9690, 3202, 3, 10);
        check("ex1_edge2_range", longint'(RANGE_OUTPUT), 40820);
        check("ex1_edge2_low", longint'(LOW_OUTPUT), 884292);

        apply(1'b1, 0, 0, 0, 0);
        apply(1'b0, 32768, 16384, 0, 2);
        check("sym0_range", longint'(RANGE_OUTPUT), 65520);
        check("sym0_low", longint'(LOW_OUTPUT), 0);

        apply(1'b1, 0, 0, 0, 0);
        apply(1'b0, 16384, 0, 1, 2);
        check("last_sym_range", longint'(RANGE_OUTPUT), 32776);
        check("last_sym_low", longint'(LOW_OUTPUT), 32760);

        apply(1'b1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step_check(1'b0, 9690, 3202, 3, 10, "stream");
            check("stream_range_norm", longint'(RANGE_OUTPUT >= 16'd32768), 1);
        end

        apply(1'b1, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            if (i == 5) begin
                step_check(1'b1, 9690, 3202, 3, 10, "midreset");
                check("midreset_range_const", longint'(RANGE_OUTPUT), 32768);
                check("midreset_low_const", longint'(LOW_OUTPUT), 0);
            end else begin
                step_check(1'b0, 9690, 3202, 3, 10, "restart");
            end
        end
        apply(1'b1, 0, 0, 0, 0);
        apply(1'b0, 9690, 3202, 3, 10);
        check("restart_edge1_range", longint'(RANGE_OUTPUT), 51744);
        check("restart_edge1_low", longint'(LOW_OUTPUT), 184608);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 29) == 0);
            ns  = $urandom_range(1, 16);
            s   = (ns > 1 && $urandom_range(0, 7) != 0) ? $urandom_range(0, ns - 1)
                                                        : $urandom_range(0, 15);
            if (s == 0 && $urandom_range(0, 1) == 1) begin
                fl = 32768 + $urandom_range(0, 32767);
            end else begin
                fl = $urandom_range(1, 32767);
            end
            fh = $urandom_range(0, (fl > 32767 ? 32767 : fl - 1));
            step_check(rst, fl, fh, s, ns, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
